// File: rtl/multu_seq.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per clock,
// fixed WIDTH+1 cycle latency, forwards the accepted opcode with the product.
module multu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6,
    parameter logic [5:0]  MULTU = 6'd25,
    parameter logic [5:0]  MADDU = 6'd1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [5:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   MulAns,
    output logic [5:0]           ans_op
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [2*WIDTH:0]   acc_q,    acc_d;
    logic [5:0]         op_q,     op_d;
    logic [2*WIDTH-1:0] mulans_q, mulans_d;
    logic [5:0]         ans_op_q, ans_op_d;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   shifted;

    always_comb begin
        // Upper WIDTH+1 bits hold the partial sum; bit WIDTH catches the carry.
        sum     = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : '0);
        shifted = {1'b0, sum, acc_q[WIDTH-1:1]};

        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        op_d     = op_q;
        mulans_d = mulans_q;
        ans_op_d = ans_op_q;

        case (state_q)
            IDLE: begin
                if (start && (op == MULTU || op == MADDU)) begin
                    mcand_d = a;
                    acc_d   = {{(WIDTH+1){1'b0}}, b};
                    op_d    = op;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = shifted;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    mulans_d = shifted[2*WIDTH-1:0];
                    ans_op_d = op_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            mulans_q <= '0;
            ans_op_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            mulans_q <= mulans_d;
            ans_op_q <= ans_op_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign MulAns = mulans_q;
    assign ans_op = ans_op_q;

endmodule

// File: tb/tb_multu_seq.sv
// Scoreboard bench for multu_seq: stimulus pushes expected product/opcode/done
// cycle; a negedge monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_multu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] MulAns;
    logic [5:0]  ans_op;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] ans;
        logic [5:0]  aop;
        int          at;
    } exp_t;

    exp_t q[$];

    multu_seq #(.WIDTH(32), .CNT_W(6), .MULTU(6'd25), .MADDU(6'd1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .MulAns(MulAns), .ans_op(ans_op)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cyc %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("mulans", MulAns, e.ans);
                chk("ans_op", 64'(ans_op), 64'(e.aop));
                chk("done_cycle", 64'(cyc), 64'(e.at));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    // Called just after a negedge; returns one negedge later with inputs scrambled.
    task automatic issue(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] ex, input bit accepted);
        exp_t e;
        if (accepted) begin
            e.ans = ex; e.aop = o; e.at = cyc + 33;
            q.push_back(e);
        end
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 6'h3f; a = $urandom; b = $urandom;
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
        chk("pending", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        logic [63:0] held;
        rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mulans", MulAns, 64'd0);
        chk("rst_ans_op", 64'(ans_op), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1: 3*5 with busy window check
        c0 = cyc;
        issue(6'd25, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b1);
        for (int k = 0; k < 34; k++) begin
            chk("busy_window", 64'(busy), 64'((cyc >= c0 + 1) && (cyc <= c0 + 32)));
            @(negedge clk);
        end
        chk("pending", 64'(q.size()), 64'd0);

        // 2: max operands via MADDU, then hold check
        issue(6'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        drain(34);
        for (int k = 0; k < 10; k++) begin
            chk("hold_mulans", MulAns, 64'hFFFF_FFFE_0000_0001);
            chk("hold_ans_op", 64'(ans_op), 64'd1);
            @(negedge clk);
        end

        // 3: start during RUN is ignored
        issue(6'd25, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1);
        repeat (9) @(negedge clk);
        chk("busy_mid", 64'(busy), 64'd1);
        start = 1'b1; op = 6'd25; a = 32'd7; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        drain(40);

        // 4: illegal opcode ignored, then zero operand
        issue(6'h20, 32'd9, 32'd9, 64'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("bad_op_busy", 64'(busy), 64'd0);
            chk("bad_op_done", 64'(done), 64'd0);
            chk("bad_op_mulans", MulAns, 64'h0000_0001_0000_0000);
            chk("bad_op_ans_op", 64'(ans_op), 64'd25);
            @(negedge clk);
        end
        issue(6'd25, 32'd0, 32'h1234_5678, 64'd0, 1'b1);
        drain(34);

        // 5: asynchronous reset mid-multiply
        issue(6'd1, 32'd6, 32'd7, 64'd42, 1'b1);
        repeat (14) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_mulans", MulAns, 64'd0);
        chk("arst_ans_op", 64'(ans_op), 64'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(6'd25, 32'd6, 32'd7, 64'd42, 1'b1);
        drain(34);

        // 6: start held high -> back-to-back accepts every 34 cycles
        c0 = cyc;
        held = 64'd6;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.ans = held; e.aop = 6'd25; e.at = c0 + 33 + 34 * k;
            q.push_back(e);
        end
        start = 1'b1; op = 6'd25; a = 32'd2; b = 32'd3;
        repeat (69) @(negedge clk);
        start = 1'b0;
        drain(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
